sram_rr_arbiter: RTL
====================

Name: sram_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port SRAM (DATA_WIDTH x 2**ADDR_WIDTH, registered read address, write-on-we) between ports A and B.
- Accepts one access per cycle and drives the SRAM data/addr/we pins.
- Returns one response per accepted access on the requester's own response channel.
- Sits between two client engines and the memory macro.

Parameters:
- DATA_WIDTH, 4, width of data bus.
- ADDR_WIDTH, 4, width of address bus.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle (grant).
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rvalid  out  1  port A response valid (read data or write ack).
- a_rdata  out  DATA_WIDTH  port A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as port A, for port B.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_data  out  DATA_WIDTH  SRAM write data.
- mem_we  out  1  SRAM write enable.
- mem_q  in  DATA_WIDTH  SRAM read data (valid the cycle after the address edge).

Behaviour:
- Clock/reset: single clock clk. rst is synchronous, active-high.
- Reset values:
  - a_rvalid = b_rvalid = 0.
  - a_rdata = b_rdata = 0.
  - Priority pointer prio = A.
  - a_ready, b_ready and mem_we are combinational and equal 0 whenever rst = 1.
- Grant (combinational, same cycle):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the port named by prio.
  - At most one of a_ready/b_ready is high. ready never asserts without valid.
  - Handshake completes when valid & ready. A requester holds all request fields stable until ready.
- SRAM drive:
  - Granted port's addr/wdata/we are routed to mem_addr/mem_data/mem_we.
  - No grant -> mem_we = 0, mem_addr = last granted address (register held, reset 0), mem_data = 0.
- Priority update (posedge): on any grant, prio <= the non-granted port. No grant -> prio unchanged.
  - Continuous contention therefore alternates A, B, A, B...
- Response pipeline (latency 1):
  - Accepted access at edge N -> x_rvalid = 1 for exactly the cycle after edge N.
  - Reads: x_rdata = mem_q in that cycle (registered-address SRAM read data).
  - Writes: x_rvalid = 1 acts as ack; x_rdata holds its previous value.
  - Responses are never back-pressured. Back-to-back accepts give back-to-back rvalid.
- States: IDLE (no response pending), RESP_A, RESP_B, tracked with a 2-bit pending register. Next state follows the grant of the current cycle, so a new grant may overlap an outstanding response.
- Read after write, same address, consecutive cycles: the read returns the newly written data. Ordering is strictly grant order.
- Reset mid-operation: the pending response is dropped (rvalid forced 0 next cycle) and prio returns to A. No SRAM write occurs in a cycle where rst = 1.
- Addresses wrap naturally at 2**ADDR_WIDTH (no range checks).

Optional Feature:
- Macro: SRAM_RR_ARBITER_STATS_EN.
- Defined: adds outputs a_grants and b_grants, each 16 bits.
  - Each counts accepted handshakes for its port; reset to 0.
  - Saturates at 16'hFFFF (no wrap).
  - Adds a stall_cycles 16-bit saturating counter: cycles with at least one valid and no ready on that port, counted once per port per cycle.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: rst = 1 for 2 cycles with a_valid = b_valid = 1 -> a_ready = b_ready = 0, mem_we = 0, rvalid = 0. After release, first contended grant goes to A.
- Single port: A writes addr 3 = 4'hA, then reads addr 3 -> a_rvalid pulses after each accept; read a_rdata = 4'hA; b_ready stays 0 throughout.
- Contention: A and B both continuously valid for 6 cycles, reads at addr 1 / addr 2 -> grants A, B, A, B, A, B. Responses alternate a_rvalid/b_rvalid with data matching mem contents of 1 and 2.
- Cross-port coherence: A writes addr 5 = 4'h7 at cycle N; B reads addr 5 at N+1 -> b_rdata = 4'h7 at N+2.
- Reset mid-op: accept a B read, assert rst the next cycle -> b_rvalid = 0; prio = A; memory contents are unchanged apart from writes completed before rst.
- STATS_EN: 20 contended cycles -> a_grants = b_grants = 10. Preload counters near max -> they saturate at 16'hFFFF.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-port round-robin arbiter in front of a single-port SRAM
// Optional grant/stall counters: define SRAM_RR_ARBITER_STATS_EN.
module sram_rr_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
`ifdef SRAM_RR_ARBITER_STATS_EN
   output logic [15:0]           a_grants,
   output logic [15:0]           b_grants,
   output logic [15:0]           stall_cycles,
`endif
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   // One-hot encoding so each rvalid is a state bit taken straight from a flop.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RESP_A = 2'b01,
      RESP_B = 2'b10
   } state_t;

   state_t                state;
   logic                  pend_rd;     // pending response is a read (else a write ack)
   logic                  prio_b;      // 0: A wins a tie, 1: B wins a tie
   logic [ADDR_WIDTH-1:0] last_addr;   // address held on the SRAM while idle
   logic [DATA_WIDTH-1:0] a_rdata_q;
   logic [DATA_WIDTH-1:0] b_rdata_q;
   logic                  gnt_a;
   logic                  gnt_b;

   // Grant: a lone requester wins, a tie goes to the priority port, nothing during reset.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst) begin
         if (a_valid && b_valid) begin
            gnt_a = !prio_b;
            gnt_b = prio_b;
         end else begin
            gnt_a = a_valid;
            gnt_b = b_valid;
         end
      end
   end

   assign a_ready = gnt_a;
   assign b_ready = gnt_b;

   // Route the granted request onto the SRAM pins; idle keeps the last address and writes nothing.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = last_addr;
      mem_data = '0;
      if (gnt_a) begin
         mem_we   = a_we;
         mem_addr = a_addr;
         mem_data = a_wdata;
      end else if (gnt_b) begin
         mem_we   = b_we;
         mem_addr = b_addr;
         mem_data = b_wdata;
      end
   end

   // Response FSM: next state follows this cycle's grant, so responses can run back to back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend_rd   <= 1'b0;
         prio_b    <= 1'b0;
         last_addr <= '0;
      end else if (gnt_a) begin
         state     <= RESP_A;
         pend_rd   <= !a_we;
         prio_b    <= 1'b1;
         last_addr <= a_addr;
      end else if (gnt_b) begin
         state     <= RESP_B;
         pend_rd   <= !b_we;
         prio_b    <= 1'b0;
         last_addr <= b_addr;
      end else begin
         state     <= IDLE;
      end
   end

   assign a_rvalid = state[0];
   assign b_rvalid = state[1];

   // Read data is the SRAM output in the response cycle; otherwise the last value is held.
   always_comb begin
      a_rdata = a_rdata_q;
      b_rdata = b_rdata_q;
      if (state == RESP_A && pend_rd) a_rdata = mem_q;
      if (state == RESP_B && pend_rd) b_rdata = mem_q;
   end

   // Hold registers for the read data shown outside read-response cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         a_rdata_q <= a_rdata;
         b_rdata_q <= b_rdata;
      end
   end

`ifdef SRAM_RR_ARBITER_STATS_EN
   logic       stall_a;
   logic       stall_b;
   logic [1:0] stall_inc;

   assign stall_a   = a_valid && !a_ready;
   assign stall_b   = b_valid && !b_ready;
   assign stall_inc = {1'b0, stall_a} + {1'b0, stall_b};

   // Saturating grant and stall counters; a cycle may add one stall per waiting port.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_grants     <= '0;
         b_grants     <= '0;
         stall_cycles <= '0;
      end else begin
         if (gnt_a && a_grants != 16'hFFFF) a_grants <= a_grants + 16'd1;
         if (gnt_b && b_grants != 16'hFFFF) b_grants <= b_grants + 16'd1;
         if (stall_cycles > 16'hFFFF - {14'd0, stall_inc})
            stall_cycles <= 16'hFFFF;
         else
            stall_cycles <= stall_cycles + {14'd0, stall_inc};
      end
   end
`endif

endmodule
